// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// Writeback-side initiator for the 32x32 register file write port. Results
// from the writeback producers are accepted over a valid/ready handshake,
// buffered in a DEPTH-entry FIFO and issued one per cycle through a
// registered output stage. Pending writes are visible through a per-register
// busy vector and a two-port forwarding lookup.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      producer handshake, transfer on posedge
//   in_reg, in_data        destination register and result value
//   wb_stall               hold off issuing to the register file
//   write_reg/write_data   registered register file write address / data
//   regWrite               registered register file write enable
//   rd_reg_1/2             decode read addresses for forwarding
//   fwd_hit_1/2            a pending write targets rd_reg_x
//   fwd_data_1/2           youngest pending value for rd_reg_x (0 if no hit)
//   busy                   bit r set while any pending write targets r
//   count                  FIFO occupancy, output stage excluded
module regfile_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_reg,
   input  logic [31:0]              in_data,
   input  logic                     wb_stall,
   output logic [4:0]               write_reg,
   output logic [31:0]              write_data,
   output logic                     regWrite,
   input  logic [4:0]               rd_reg_1,
   input  logic [4:0]               rd_reg_2,
   output logic                     fwd_hit_1,
   output logic                     fwd_hit_2,
   output logic [31:0]              fwd_data_1,
   output logic [31:0]              fwd_data_2,
   output logic [31:0]              busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [4:0]       mem_reg_q  [DEPTH];
   logic [31:0]      mem_data_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [4:0]       wreg_q, wreg_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             we_q, we_d;

   logic accept_nz;
   logic pop;
   logic bypass;
   logic push;

   assign in_ready  = !rst && (count_q < DEPTH_C);
   // Register 0 writes complete the handshake but are otherwise dropped.
   assign accept_nz = in_valid && in_ready && (in_reg != 5'd0);
   assign pop       = !wb_stall && (count_q != '0);
   // Bypass only when the FIFO is empty so queued entries are never overtaken.
   assign bypass    = !wb_stall && (count_q == '0) && accept_nz;
   assign push      = accept_nz && !bypass;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      if (pop) begin
         wreg_d   = mem_reg_q[rd_ptr_q];
         wdata_d  = mem_data_q[rd_ptr_q];
         we_d     = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else if (bypass) begin
         wreg_d  = in_reg;
         wdata_d = in_data;
         we_d    = 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
      end
   end

   // Storage carries no reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_reg_q[wr_ptr_q]  <= in_reg;
         mem_data_q[wr_ptr_q] <= in_data;
      end
   end

   assign write_reg  = wreg_q;
   assign write_data = wdata_q;
   assign regWrite   = we_q;
   assign count      = count_q;

   always_comb begin
      busy = '0;
      if (we_q) begin
         busy[wreg_q] = 1'b1;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if ((PTR_W+1)'(k) < count_q) begin
            busy[mem_reg_q[rd_ptr_q + PTR_W'(k)]] = 1'b1;
         end
      end
   end

   // Search oldest to youngest so the last match (youngest) wins; the output
   // stage is older than every FIFO entry, so it is checked first.
   function automatic logic [32:0] lookup(input logic [4:0] rd);
      logic [32:0] res;
      res = '0;
      if (rd != 5'd0) begin
         if (we_q && (wreg_q == rd)) begin
            res = {1'b1, wdata_q};
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (((PTR_W+1)'(k) < count_q) &&
                (mem_reg_q[rd_ptr_q + PTR_W'(k)] == rd)) begin
               res = {1'b1, mem_data_q[rd_ptr_q + PTR_W'(k)]};
            end
         end
      end
      return res;
   endfunction

   assign {fwd_hit_1, fwd_data_1} = lookup(rd_reg_1);
   assign {fwd_hit_2, fwd_data_2} = lookup(rd_reg_2);

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [31:0] in_data;
   logic        wb_stall;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        regWrite;
   logic [4:0]  rd_reg_1;
   logic [4:0]  rd_reg_2;
   logic        fwd_hit_1;
   logic        fwd_hit_2;
   logic [31:0] fwd_data_1;
   logic [31:0] fwd_data_2;
   logic [31:0] busy;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   regfile_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_reg     (in_reg),
      .in_data    (in_data),
      .wb_stall   (wb_stall),
      .write_reg  (write_reg),
      .write_data (write_data),
      .regWrite   (regWrite),
      .rd_reg_1   (rd_reg_1),
      .rd_reg_2   (rd_reg_2),
      .fwd_hit_1  (fwd_hit_1),
      .fwd_hit_2  (fwd_hit_2),
      .fwd_data_1 (fwd_data_1),
      .fwd_data_2 (fwd_data_2),
      .busy       (busy),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every issued write must match the oldest expected write.
   always @(negedge clk) begin
      if (regWrite === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got reg %0d data 0x%0h expected no write",
                     write_reg, write_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({write_reg, write_data} !== e) begin
               errors++;
               $display("FAIL wb_order: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                        write_reg, write_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic push(input logic [4:0] r, input logic [31:0] d, input bit exp);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got in_ready 0 expected 1 for reg %0d", r);
      end else begin
         if (exp && r != 5'd0) exp_q.push_back({r, d});
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(count == 0 && regWrite == 1'b0) && n < 50) begin
         tick();
         n++;
      end
      check(name, {31'd0, (count == 0 && regWrite == 1'b0)}, 32'd1);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_reg   = '0;
      in_data  = '0;
      wb_stall = 1'b0;
      rd_reg_1 = 5'd5;
      rd_reg_2 = 5'd0;
      tick();
      tick();
      check("rst_regWrite", {31'd0, regWrite}, 32'd0);
      check("rst_write_reg", {27'd0, write_reg}, 32'd0);
      check("rst_write_data", write_data, 32'd0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_fwd_hit_1", {31'd0, fwd_hit_1}, 32'd0);
      rst = 1'b0;
      tick();

      // Single write through the bypass path
      in_valid = 1'b1; in_reg = 5'd15; in_data = 32'd5;
      exp_q.push_back({5'd15, 32'd5});
      tick();
      in_valid = 1'b0;
      check("lat_regWrite", {31'd0, regWrite}, 32'd1);
      check("lat_busy15_on", {31'd0, busy[15]}, 32'd1);
      tick();
      check("lat_busy15_off", {31'd0, busy[15]}, 32'd0);
      check("lat_regWrite_off", {31'd0, regWrite}, 32'd0);

      // Fill under stall, back-pressure, then ordered drain
      wb_stall = 1'b1;
      for (int i = 1; i <= 4; i++) push(5'(i), 32'(i), 1'b1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_count", {29'd0, count}, 32'd4);
      check("full_busy", busy, 32'h0000_001E);
      in_valid = 1'b1; in_reg = 5'd5; in_data = 32'd5;
      tick();
      check("full_hold_count", {29'd0, count}, 32'd4);
      check("full_hold_regWrite", {31'd0, regWrite}, 32'd0);
      wb_stall = 1'b0;
      push(5'd5, 32'd5, 1'b1);
      wait_idle("drain1_idle");

      // Duplicate destination, youngest forwards
      wb_stall = 1'b1;
      push(5'd20, 32'd3, 1'b1);
      push(5'd20, 32'd9, 1'b1);
      rd_reg_1 = 5'd20;
      rd_reg_2 = 5'd20;
      #1;
      check("dup_hit_1", {31'd0, fwd_hit_1}, 32'd1);
      check("dup_data_1", fwd_data_1, 32'd9);
      check("dup_data_2", fwd_data_2, 32'd9);
      wb_stall = 1'b0;
      tick();
      check("dup_after_pop_data", fwd_data_1, 32'd9);
      wait_idle("drain2_idle");
      check("dup_hit_after", {31'd0, fwd_hit_1}, 32'd0);

      // Register 0 is accepted and discarded
      rd_reg_2 = 5'd0;
      push(5'd0, 32'hDEAD, 1'b0);
      check("r0_regWrite", {31'd0, regWrite}, 32'd0);
      check("r0_busy", busy, 32'd0);
      check("r0_count", {29'd0, count}, 32'd0);
      check("r0_fwd_hit_2", {31'd0, fwd_hit_2}, 32'd0);

      // Full FIFO with simultaneous push and pop across pointer wrap
      wb_stall = 1'b1;
      for (int i = 0; i < 4; i++) push(5'(6 + i), 32'(50 + i), 1'b1);
      wb_stall = 1'b0;
      tick();
      check("wrap_start_count", {29'd0, count}, 32'd3);
      for (int i = 0; i < 2 * DEPTH; i++) begin
         in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'(100 + i);
         check("wrap_in_ready", {31'd0, in_ready}, 32'd1);
         exp_q.push_back({5'(10 + i), 32'(100 + i)});
         tick();
         check("wrap_count", {29'd0, count}, 32'd3);
      end
      in_valid = 1'b0;
      wait_idle("drain3_idle");

      // Mid-operation reset drops everything queued
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) push(5'(21 + i), 32'(200 + i), 1'b0);
      check("pre_rst_count", {29'd0, count}, 32'd3);
      rst = 1'b1;
      tick();
      check("mrst_regWrite", {31'd0, regWrite}, 32'd0);
      check("mrst_count", {29'd0, count}, 32'd0);
      check("mrst_busy", busy, 32'd0);
      rst = 1'b0;
      wb_stall = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("post_rst_count", {29'd0, count}, 32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
